// File: rtl/pump_pkg.sv
// Shared types and constants for the three-pump dose arbiter.
package pump_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_GAP
   } state_t;

   localparam int NUM_PUMPS = 3;
   localparam logic PUMP_OFF = 1'b1;
   localparam logic [NUM_PUMPS-1:0] ALL_OFF = {NUM_PUMPS{PUMP_OFF}};

   // Seconds-to-cycles; a zero (or negative) product still yields one cycle.
   function automatic logic [31:0] dur_cycles(input longint secs, input longint freq);
      longint prod;
      prod = secs * freq;
      if (prod <= 0) return 32'd1;
      return 32'(prod);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick of one pending pump, searching upward from the pointer.
module rr_picker
   import pump_pkg::*;
(
   input  logic [NUM_PUMPS-1:0] pending,
   input  logic [1:0]           pointer,
   output logic [NUM_PUMPS-1:0] grant,
   output logic                 valid
);

   logic [NUM_PUMPS-1:0] rot;
   logic [NUM_PUMPS-1:0] pick;

   // Rotate so the pointer's pump sits at bit 0, priority-pick, rotate back.
   always_comb begin
      case (pointer)
         2'd1:    rot = {pending[0], pending[2:1]};
         2'd2:    rot = {pending[1:0], pending[2]};
         default: rot = pending;
      endcase

      if (rot[0])      pick = 3'b001;
      else if (rot[1]) pick = 3'b010;
      else if (rot[2]) pick = 3'b100;
      else             pick = 3'b000;

      case (pointer)
         2'd1:    grant = {pick[1:0], pick[2]};
         2'd2:    grant = {pick[0], pick[2:1]};
         default: grant = pick;
      endcase
   end

   assign valid = |pending;

endmodule

// File: rtl/pump_dose_arbiter.sv
// Grants timed doses to one of three pumps at a time, round-robin, with a
// mandatory all-off gap after every dose or abort.
module pump_dose_arbiter
   import pump_pkg::*;
#(
   parameter int CLOCK_FREQ = 1_000_000,
   parameter int ON_TIME_S  = 5,
   parameter int GAP_S      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_PUMPS-1:0] req,
   input  logic [NUM_PUMPS-1:0] cancel,
   output logic [NUM_PUMPS-1:0] pump_out,
   output logic [1:0]           active_id,
   output logic                 busy,
   output logic [NUM_PUMPS-1:0] done
);

   localparam logic [31:0] ON_CYC  = dur_cycles(longint'(ON_TIME_S), longint'(CLOCK_FREQ));
   localparam logic [31:0] GAP_CYC = dur_cycles(longint'(GAP_S), longint'(CLOCK_FREQ));

   state_t               state;
   logic [NUM_PUMPS-1:0] pending;
   logic [1:0]           rr_ptr;
   logic [31:0]          cnt;

   logic [NUM_PUMPS-1:0] live_pending;
   logic [NUM_PUMPS-1:0] grant;
   logic                 grant_vld;
   logic                 do_grant;
   logic [NUM_PUMPS-1:0] pend_clr;
   logic                 abort;
   logic [1:0]           grant_id;

   // A cancel arriving in the grant cycle must still prevent that dose.
   assign live_pending = pending & ~cancel;

   rr_picker u_rr (
      .pending (live_pending),
      .pointer (rr_ptr),
      .grant   (grant),
      .valid   (grant_vld)
   );

   assign do_grant = (state == ST_IDLE) && enable && grant_vld;
   assign pend_clr = do_grant ? grant : '0;
   // In RUN the only low pump_out bit marks the active pump.
   assign abort    = !enable || (|(cancel & ~pump_out));

   always_comb begin
      case (grant)
         3'b010:  grant_id = 2'd2;
         3'b100:  grant_id = 2'd3;
         default: grant_id = 2'd1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         pending   <= '0;
         rr_ptr    <= 2'd0;
         cnt       <= '0;
         pump_out  <= ALL_OFF;
         active_id <= 2'd0;
         busy      <= 1'b0;
         done      <= '0;
      end else begin
         pending <= (pending | req) & ~cancel & ~pend_clr;
         done    <= '0;
         case (state)
            ST_IDLE: begin
               if (do_grant) begin
                  state     <= ST_RUN;
                  cnt       <= ON_CYC - 32'd1;
                  pump_out  <= ~grant;
                  active_id <= grant_id;
                  busy      <= 1'b1;
                  rr_ptr    <= (grant_id == 2'd3) ? 2'd0 : grant_id;
               end
            end
            ST_RUN: begin
               if (abort || cnt == 32'd0) begin
                  if (!abort) done <= ~pump_out;
                  state     <= ST_GAP;
                  cnt       <= GAP_CYC - 32'd1;
                  pump_out  <= ALL_OFF;
                  active_id <= 2'd0;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            ST_GAP: begin
               if (cnt == 32'd0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pump_dose_arbiter.sv
// Scoreboard bench: stimulus queues expected output-change events, a monitor
// pops and compares each time any output changes.
module tb_pump_dose_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] req;
   logic [2:0] cancel;
   logic [2:0] pump_out;
   logic [1:0] active_id;
   logic       busy;
   logic [2:0] done;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int         t;
      logic [2:0] po;
      logic [2:0] dn;
      logic       bz;
      logic [1:0] id;
   } ev_t;

   ev_t q[$];

   pump_dose_arbiter #(
      .CLOCK_FREQ (4),
      .ON_TIME_S  (2),
      .GAP_S      (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .req       (req),
      .cancel    (cancel),
      .pump_out  (pump_out),
      .active_id (active_id),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int t, input logic [2:0] po, input logic [2:0] dn,
                       input logic bz, input logic [1:0] id);
      ev_t e;
      e.t = t; e.po = po; e.dn = dn; e.bz = bz; e.id = id;
      q.push_back(e);
   endtask

   // Full dose of pump p granted at edge g: on 8 cycles, done pulse, 4-cycle gap.
   task automatic exp_dose(input int p, input int g);
      logic [2:0] m;
      logic [2:0] d;
      m = 3'b111; m[p-1] = 1'b0;
      d = 3'b000; d[p-1] = 1'b1;
      push(g,      m,      3'b000, 1'b1, 2'(p));
      push(g + 8,  3'b111, d,      1'b1, 2'd0);
      push(g + 9,  3'b111, 3'b000, 1'b1, 2'd0);
      push(g + 12, 3'b111, 3'b000, 1'b0, 2'd0);
   endtask

   // Drive for one cycle from a negedge; n is the edge that samples it.
   task automatic pulse(input logic [2:0] r, input logic [2:0] c, output int n);
      req = r; cancel = c;
      n = cyc + 1;
      @(negedge clk);
      req = 3'b000; cancel = 3'b000;
   endtask

   task automatic wait_cyc(input int t);
      int k;
      k = 0;
      while (cyc < t && k < 1000) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (q.size() > 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL %s drain: %0d expected events never seen, required 0", nm, q.size());
         q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Monitor: every change of any output is one compared event.
   initial begin
      ev_t prev, cur, e;
      @(negedge clk);
      prev.po = pump_out; prev.dn = done; prev.bz = busy; prev.id = active_id;
      forever begin
         @(negedge clk);
         cur.t = cyc; cur.po = pump_out; cur.dn = done; cur.bz = busy; cur.id = active_id;
         if (cur.po !== prev.po || cur.dn !== prev.dn || cur.bz !== prev.bz || cur.id !== prev.id) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_event: t=%0d po=%b done=%b busy=%b id=%0d, required no change",
                        cur.t, cur.po, cur.dn, cur.bz, cur.id);
            end else begin
               e = q.pop_front();
               if (cur.t != e.t || cur.po !== e.po || cur.dn !== e.dn || cur.bz !== e.bz || cur.id !== e.id) begin
                  fails++;
                  $display("FAIL event: got t=%0d po=%b done=%b busy=%b id=%0d, required t=%0d po=%b done=%b busy=%b id=%0d",
                           cur.t, cur.po, cur.dn, cur.bz, cur.id, e.t, e.po, e.dn, e.bz, e.id);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      int n, g;
      rst = 1'b1; enable = 1'b1; req = 3'b000; cancel = 3'b000;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_pump_out", 32'(pump_out), 32'h7);
      chk("reset_active_id", 32'(active_id), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single dose on pump1
      pulse(3'b001, 3'b000, n);
      exp_dose(1, n + 1);
      drain("single");

      // Three simultaneous requests after reset, served in order 1,2,3
      do_reset();
      pulse(3'b111, 3'b000, n);
      exp_dose(1, n + 1);
      exp_dose(2, n + 14);
      exp_dose(3, n + 27);
      drain("three");

      // Cancel pump2 on its third RUN cycle
      pulse(3'b010, 3'b000, n);
      g = n + 1;
      push(g,     3'b101, 3'b000, 1'b1, 2'd2);
      push(g + 3, 3'b111, 3'b000, 1'b1, 2'd0);
      push(g + 7, 3'b111, 3'b000, 1'b0, 2'd0);
      wait_cyc(g + 2);
      pulse(3'b000, 3'b010, n);
      chk("cancel_edge", 32'(n), 32'(g + 3));
      drain("cancel");

      // Simultaneous req and cancel on pump3: nothing happens
      pulse(3'b100, 3'b100, n);
      repeat (20) @(negedge clk);
      chk("reqcancel_busy", 32'(busy), 32'h0);
      chk("reqcancel_pump_out", 32'(pump_out), 32'h7);

      // Request held while disabled, dose starts one cycle after enable
      enable = 1'b0;
      pulse(3'b001, 3'b000, n);
      repeat (5) @(negedge clk);
      chk("disabled_busy", 32'(busy), 32'h0);
      chk("disabled_pump_out", 32'(pump_out), 32'h7);
      enable = 1'b1;
      exp_dose(1, cyc + 1);
      drain("enable");

      // Dropping enable mid-RUN aborts without done
      pulse(3'b010, 3'b000, n);
      g = n + 1;
      push(g,     3'b101, 3'b000, 1'b1, 2'd2);
      push(g + 2, 3'b111, 3'b000, 1'b1, 2'd0);
      push(g + 6, 3'b111, 3'b000, 1'b0, 2'd0);
      wait_cyc(g + 1);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      drain("enable_abort");

      // Reset mid-RUN with pump3 pending: dose dropped, nothing restarts
      pulse(3'b001, 3'b000, n);
      g = n + 1;
      push(g, 3'b110, 3'b000, 1'b1, 2'd1);
      wait_cyc(g + 2);
      pulse(3'b100, 3'b000, n);
      #2;
      rst = 1'b1;
      push(cyc + 1, 3'b111, 3'b000, 1'b0, 2'd0);
      #1;
      chk("rst_async_pump_out", 32'(pump_out), 32'h7);
      chk("rst_async_busy", 32'(busy), 32'h0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'h0);
      drain("reset_run");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pump_dose_arbiter.md
PUMP_DOSE_ARBITER -- requirements
Module: pump_dose_arbiter

Interface
REQ-001 Parameter CLOCK_FREQ, default 1_000_000, clk cycles per second.
REQ-002 Parameter ON_TIME_S, default 5, pump on-time per dose in seconds.
REQ-003 Parameter GAP_S, default 1, mandatory all-off gap after each dose in seconds.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  high = arbitration allowed; low = no new grant, active dose aborted.
REQ-007 req  input  3  per-pump dose request pulse; bit0 = pump1, bit1 = pump2, bit2 = pump3.
REQ-008 cancel  input  3  per-pump cancel pulse; clears the pending request and aborts the dose if that pump is active.
REQ-009 pump_out  output  3  active-low pump drive; 1 = off.
REQ-010 active_id  output  2  0 = none, 1..3 = pump currently driven.
REQ-011 busy  output  1  high in RUN or GAP.
REQ-012 done  output  3  one-cycle pulse per pump on dose completion (not on abort).

Function
REQ-013 The block SHALL hold one pending flag per pump; req sets it, grant clears it, cancel clears it; cancel wins over a simultaneous req; req while pending has no further effect.
REQ-014 FSM states SHALL be IDLE, RUN, GAP.
REQ-015 IDLE: when enable=1 and any pending flag is set, it SHALL grant one pump, clear that flag, load the on-counter and enter RUN on the same edge.
REQ-016 Grant order SHALL be round-robin, starting from the pump after the last granted one; the pointer resets to pump1.
REQ-017 RUN: pump_out bit of the granted pump SHALL be 0 for exactly ON_TIME_S*CLOCK_FREQ cycles; all other bits 1.
REQ-018 RUN end: done bit of the granted pump SHALL pulse for exactly one cycle, coincident with the first GAP cycle; then enter GAP.
REQ-019 Abort (cancel of active pump, or enable=0, during RUN): pump_out SHALL be 3'b111 from the next cycle; no done pulse; enter GAP.
REQ-020 GAP: pump_out SHALL be 3'b111 for exactly GAP_S*CLOCK_FREQ cycles, then enter IDLE; cancel/req only update pending flags.
REQ-021 Latency: req sampled at edge N sets pending at N; pump_out falls after edge N+1 when IDLE and enabled.
REQ-022 A req for the active pump during RUN or GAP SHALL set its pending flag (re-queued dose).
REQ-023 Counters SHALL be 32-bit; a computed duration of 0 SHALL be treated as 1 cycle.
REQ-024 At most one pump_out bit SHALL be 0 in any cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On rst=1, asynchronously: state IDLE, pending 3'b000, round-robin pointer pump1, counters 0, pump_out 3'b111, active_id 0, busy 0, done 3'b000.
REQ-027 Reset mid-RUN SHALL drop the dose and discard all pending requests.

Structure
REQ-028 Shared package pump_pkg SHALL hold the state enum, NUM_PUMPS = 3 and PUMP_OFF = 1'b1.
REQ-029 Round-robin selection SHALL be one sub-module, rr_picker (pending[2:0], pointer -> grant one-hot, valid).

Verification (CLOCK_FREQ=4, ON_TIME_S=2 -> 8 cycles, GAP_S=1 -> 4 cycles)
REQ-030 req=3'b001 for one cycle -> pump_out=3'b110 for 8 cycles, done=3'b001 for 1 cycle, 3'b111 for 4 cycles, then busy=0.
REQ-031 req=3'b111 in one cycle after reset -> doses run in order pump1, pump2, pump3, each 8 on + 4 gap, three done pulses.
REQ-032 cancel=3'b010 on RUN cycle 3 of pump2 -> pump_out=3'b111 next cycle, no done, 4-cycle GAP.
REQ-033 req=3'b100 and cancel=3'b100 in the same IDLE cycle -> no dose; busy stays 0.
REQ-034 enable=0 with req=3'b001 -> idle and pending held; enable=1 -> pump_out=3'b110 one cycle later.
REQ-035 rst pulse during RUN with pump3 pending -> pump_out=3'b111 immediately; after release, no dose starts.
